// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the gpio input conditioner.
// Optional edge/irq logic is controlled by GPIO_COND_IRQ_EN.
package gpio_cond_pkg;

  localparam int unsigned GPIO_COND_WIDTH  = 16;
  localparam int unsigned GPIO_COND_SYNC   = 2;
  localparam int unsigned GPIO_COND_DB_CNT = 4;

  // Ceiling log2, usable in constant expressions for counter widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pad-side bundle of the gpio input conditioner; master drives pads, slave conditions them.
// Edge/irq signals exist only with GPIO_COND_IRQ_EN.
interface gpio_in_conditioner_if
  import gpio_cond_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_COND_WIDTH
);

  logic [WIDTH-1:0] gpio_raw_i;
  logic [WIDTH-1:0] gpio_bi_o;
`ifdef GPIO_COND_IRQ_EN
  logic [WIDTH-1:0] irq_clr_i;
  logic [WIDTH-1:0] edge_pend_o;
  logic             irq_o;
`endif

  modport master (
`ifdef GPIO_COND_IRQ_EN
    output irq_clr_i,
    input  edge_pend_o,
    input  irq_o,
`endif
    output gpio_raw_i,
    input  gpio_bi_o
  );

  modport slave (
`ifdef GPIO_COND_IRQ_EN
    input  irq_clr_i,
    output edge_pend_o,
    output irq_o,
`endif
    input  gpio_raw_i,
    output gpio_bi_o
  );

endinterface

// File: rtl/gpio_debounce_ch.sv
// One conditioner channel: synchroniser chain, debounce counter and accepted level.
// With GPIO_COND_IRQ_EN a sticky pending flag records every accepted change.
module gpio_debounce_ch
  import gpio_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = GPIO_COND_SYNC,
  parameter int unsigned DB_CNT      = GPIO_COND_DB_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
`ifdef GPIO_COND_IRQ_EN
  input  logic clr,
  output logic pend,
`endif
  output logic state
);

  localparam int unsigned CW = clog2(DB_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sync;
  logic                   mismatch;
  logic                   accept;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync != state);
  assign accept   = tick && mismatch && (cnt_q == CW'(DB_CNT - 1));

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      state <= 1'b0;
    end else if (tick) begin
      if (!mismatch) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= '0;
        state <= sync;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

`ifdef GPIO_COND_IRQ_EN
  // A new accepted change beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pend <= 1'b0;
    else if (accept) pend <= 1'b1;
    else if (clr)    pend <= 1'b0;
  end
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronises and debounces raw pad inputs feeding the gpio peripheral's input register.
// Define GPIO_COND_IRQ_EN to add per-bit sticky edge flags and an irq output.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned WIDTH       = GPIO_COND_WIDTH,
  parameter int unsigned SYNC_STAGES = GPIO_COND_SYNC,
  parameter int unsigned PRESC_DIV   = 1,
  parameter int unsigned DB_CNT      = GPIO_COND_DB_CNT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gpio_in_conditioner_if.slave  bus
);

  localparam int unsigned PW = (PRESC_DIV > 1) ? clog2(PRESC_DIV) : 1;

  logic [PW-1:0]    presc_q;
  logic             tick;
  logic [WIDTH-1:0] state_v;
`ifdef GPIO_COND_IRQ_EN
  logic [WIDTH-1:0] pend_v;
`endif

  // Shared sample-tick prescaler; with PRESC_DIV=1 it sits at 0 and ticks every cycle.
  assign tick = (presc_q == PW'(PRESC_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpio_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT      (DB_CNT)
    ) u_ch (
      .clk   (clk_i),
      .rst   (rst_i),
      .tick  (tick),
      .raw   (bus.gpio_raw_i[i]),
`ifdef GPIO_COND_IRQ_EN
      .clr   (bus.irq_clr_i[i]),
      .pend  (pend_v[i]),
`endif
      .state (state_v[i])
    );
  end

  assign bus.gpio_bi_o = state_v;
`ifdef GPIO_COND_IRQ_EN
  assign bus.edge_pend_o = pend_v;
  assign bus.irq_o       = |pend_v;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner: PRESC_DIV=1 and PRESC_DIV=10 instances share stimulus.
// Edge/irq checks are included when GPIO_COND_IRQ_EN is defined.
module tb_gpio_in_conditioner;

  localparam int unsigned W    = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned MAXE = 4096;

  typedef struct packed {
    logic [15:0] bi1;
    logic [15:0] bi10;
    logic [15:0] pd1;
    logic [15:0] pd10;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.WIDTH(W)) bus1 ();
  gpio_in_conditioner_if #(.WIDTH(W)) bus10 ();

  gpio_in_conditioner #(.WIDTH(W)) u1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  gpio_in_conditioner #(.WIDTH(W), .PRESC_DIV(10)) u10 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus10)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Reference model: edge count since reset, raw history, and history of tick samples.
  int unsigned ecnt [2];
  int unsigned nt   [2];
  logic [15:0] rawh [2][MAXE];
  logic [15:0] tsh  [2][MAXE];
  logic [15:0] mstate [2];
  logic [15:0] mpend  [2];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // A bit flips once the last DB tick samples of the raw input, delayed by SYNC edges,
  // all disagree with the current level.
  task automatic model_step(input logic [15:0] r, input logic [15:0] c, input logic rv,
                            output exp_t e);
    for (int d = 0; d < 2; d++) begin
      int unsigned p;
      logic [15:0] dl;
      logic [15:0] acc;
      p = (d == 0) ? 1 : 10;
      if (rv) begin
        ecnt[d] = 0; nt[d] = 0; mstate[d] = '0; mpend[d] = '0;
      end else begin
        ecnt[d]++;
        rawh[d][ecnt[d]] = r;
        dl  = (ecnt[d] > SYNC) ? rawh[d][ecnt[d]-SYNC] : 16'h0;
        acc = '0;
        if ((ecnt[d] % p) == 0) begin
          tsh[d][nt[d]] = dl;
          nt[d]++;
          if (nt[d] >= DB) begin
            for (int i = 0; i < 16; i++) begin
              logic all;
              all = 1'b1;
              for (int j = 1; j <= int'(DB); j++)
                if (tsh[d][nt[d]-j][i] == mstate[d][i]) all = 1'b0;
              acc[i] = all;
            end
          end
        end
        mstate[d] = mstate[d] ^ acc;
        mpend[d]  = acc | (mpend[d] & ~c);
      end
    end
    e.bi1 = mstate[0]; e.bi10 = mstate[1]; e.pd1 = mpend[0]; e.pd10 = mpend[1];
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] c, input logic rv);
    exp_t e;
    @(negedge clk);
    rst = rv;
    bus1.gpio_raw_i  = r;
    bus10.gpio_raw_i = r;
`ifdef GPIO_COND_IRQ_EN
    bus1.irq_clr_i  = c;
    bus10.irq_clr_i = c;
`endif
    model_step(r, c, rv, e);
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_bi_p1", bus1.gpio_bi_o, e.bi1);
        check("sb_bi_p10", bus10.gpio_bi_o, e.bi10);
`ifdef GPIO_COND_IRQ_EN
        check("sb_pend_p1", bus1.edge_pend_o, e.pd1);
        check("sb_pend_p10", bus10.edge_pend_o, e.pd10);
        check("sb_irq_p1", 16'(bus1.irq_o), 16'(|e.pd1));
        check("sb_irq_p10", 16'(bus10.irq_o), 16'(|e.pd10));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] raw_v;
    logic        rv;
    bus1.gpio_raw_i  = 16'hFFFF;
    bus10.gpio_raw_i = 16'hFFFF;
`ifdef GPIO_COND_IRQ_EN
    bus1.irq_clr_i  = '0;
    bus10.irq_clr_i = '0;
`endif

    // Reset held with all pads high, then release.
    for (int k = 0; k < 3; k++) begin
      step(16'hFFFF, 16'h0, 1'b1);
      after_edge();
      check("rst_bi_p1", bus1.gpio_bi_o, 16'h0);
      check("rst_bi_p10", bus10.gpio_bi_o, 16'h0);
`ifdef GPIO_COND_IRQ_EN
      check("rst_irq", 16'(bus1.irq_o), 16'h0);
`endif
    end
    step(16'hFFFF, 16'h0, 1'b0);
    after_edge();
    check("release_bi", bus1.gpio_bi_o, 16'h0);
    for (int k = 0; k < 12; k++) step(16'h0, 16'h0, 1'b0);

    // Clean rise on bit 0 lands on edge 6.
    for (int k = 1; k <= 8; k++) begin
      step(16'h0001, 16'h0, 1'b0);
      after_edge();
      check("rise_edge6", 16'(bus1.gpio_bi_o[0]), (k >= 6) ? 16'h1 : 16'h0);
    end

    // Three-cycle glitch on bit 1 is discarded.
    for (int k = 0; k < 13; k++) begin
      step((k < 3) ? 16'h0003 : 16'h0001, 16'h0, 1'b0);
      after_edge();
      check("glitch_bit1", 16'(bus1.gpio_bi_o[1]), 16'h0);
    end

    // Prescaled channel latency window.
    step(16'h0, 16'h0, 1'b1);
    step(16'h0, 16'h0, 1'b1);
    for (int k = 1; k <= 55; k++) begin
      step(16'h0004, 16'h0, 1'b0);
      after_edge();
      if (k <= 31) check("presc_early", 16'(bus10.gpio_bi_o[2]), 16'h0);
      if (k >= 51) check("presc_late", 16'(bus10.gpio_bi_o[2]), 16'h1);
    end

    // Reset mid-count restarts the debounce.
    step(16'h0, 16'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(16'h0008, 16'h0, (k == 4));
      after_edge();
      check("midrst_hold", 16'(bus1.gpio_bi_o[3]), 16'h0);
    end
    for (int k = 1; k <= 8; k++) begin
      step(16'h0008, 16'h0, 1'b0);
      after_edge();
      check("midrst_rise", 16'(bus1.gpio_bi_o[3]), (k >= 6) ? 16'h1 : 16'h0);
    end

`ifdef GPIO_COND_IRQ_EN
    // Pending flag set, cleared, and a clear colliding with a new change.
    step(16'h0, 16'h0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(16'h0010, 16'h0, 1'b0);
      after_edge();
      check("pend_set", 16'(bus1.edge_pend_o[4]), (k >= 6) ? 16'h1 : 16'h0);
      check("irq_set", 16'(bus1.irq_o), (k >= 6) ? 16'h1 : 16'h0);
    end
    step(16'h0010, 16'h0010, 1'b0);
    after_edge();
    check("pend_clr", 16'(bus1.edge_pend_o[4]), 16'h0);
    check("irq_clr", 16'(bus1.irq_o), 16'h0);
    for (int k = 1; k <= 6; k++) begin
      step(16'h0, (k == 6) ? 16'h0010 : 16'h0, 1'b0);
      after_edge();
      check("pend_set_wins", 16'(bus1.edge_pend_o[4]), (k >= 6) ? 16'h1 : 16'h0);
    end
`endif

    // Random pad activity alternating quiet and noisy phases, with occasional resets.
    raw_v = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] m;
      if (((i / 300) % 2) == 1)
        m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      else
        m = 16'($urandom) & 16'($urandom) & 16'($urandom) &
            16'($urandom) & 16'($urandom) & 16'($urandom);
      raw_v = raw_v ^ m;
      rv = ($urandom_range(0, 499) == 0) || (ecnt[0] >= MAXE - 8);
      step(raw_v, 16'($urandom) & 16'($urandom) & 16'($urandom), rv);
    end
    after_edge();
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
